// File: rtl/row_feeder_pkg.sv
// rtl/row_feeder_pkg.sv - shared widths, frame defaults and FSM encoding for row_feeder
package row_feeder_pkg;

    localparam int PRECISION = 8;
    localparam int CROW      = 3;
    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;

    typedef enum logic [1:0] {
        RF_IDLE   = 2'd0,
        RF_FILL   = 2'd1,
        RF_STREAM = 2'd2,
        RF_DONE   = 2'd3
    } rf_state_e;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port RAM, one write port, one registered read port
module line_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/row_feeder.sv
// rtl/row_feeder.sv - raster pixel stream to vertically aligned 3-row columns for the window cache
module row_feeder
    import row_feeder_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          module_en,
    input  logic                          frame_start,
    input  logic [PRECISION-1:0]          pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [PRECISION*CROW-1:0]     row_data,
    output logic [CROW-1:0]               din_valid,
    output logic                          row_switch_en,
    output logic                          over
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = 2 * PRECISION;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    rf_state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          acc;

    logic                 s1_valid_q, s1_valid_d;
    logic [PRECISION-1:0] s1_pix_q, s1_pix_d;
    logic [CW-1:0]        s1_col_q, s1_col_d;
    logic                 s1_out_q, s1_out_d;
    logic                 s1_eol_q, s1_eol_d;
    logic                 s1_last_q, s1_last_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [PRECISION-1:0] s2_pix_q, s2_pix_d;
    logic [CW-1:0]        s2_col_q, s2_col_d;
    logic                 s2_out_q, s2_out_d;
    logic                 s2_eol_q, s2_eol_d;
    logic                 s2_last_q, s2_last_d;

    logic [PRECISION*CROW-1:0] row_data_q, row_data_d;
    logic                      dv_q, dv_d;
    logic                      rse_q, rse_d;
    logic                      last_out_q, last_out_d;
    logic                      over_q, over_d;

    logic [LW-1:0] rd_data;
    logic [LW-1:0] ram_wdata;
    logic          ram_re;
    logic          ram_we;

    assign pix_ready = module_en && (state_q == RF_FILL || state_q == RF_STREAM);
    assign acc       = pix_valid && pix_ready && !frame_start;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (frame_start) begin
            state_d = RF_FILL;
            col_d   = '0;
            row_d   = '0;
        end else begin
            if (acc) begin
                col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end
            case (state_q)
                RF_FILL:   if (acc && row_q == RW'(1) && col_q == COL_LAST) state_d = RF_STREAM;
                RF_STREAM: if (acc && row_q == ROW_LAST && col_q == COL_LAST) state_d = RF_DONE;
                RF_DONE:   if (over_q) state_d = RF_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    // Stage 1 holds the accepted pixel and addresses the RAM; stage 2 sees the read data.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pix_d   = s1_pix_q;
        s1_col_d   = s1_col_q;
        s1_out_d   = s1_out_q;
        s1_eol_d   = s1_eol_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_pix_d   = s2_pix_q;
        s2_col_d   = s2_col_q;
        s2_out_d   = s2_out_q;
        s2_eol_d   = s2_eol_q;
        s2_last_d  = s2_last_q;
        row_data_d = row_data_q;
        dv_d       = 1'b0;
        rse_d      = 1'b0;
        last_out_d = 1'b0;
        if (module_en) begin
            s1_valid_d = acc;
            s1_pix_d   = pix_in;
            s1_col_d   = col_q;
            s1_out_d   = (row_q >= RW'(2));
            s1_eol_d   = (col_q == COL_LAST);
            s1_last_d  = acc && state_q == RF_STREAM && row_q == ROW_LAST && col_q == COL_LAST;
            s2_valid_d = s1_valid_q;
            s2_pix_d   = s1_pix_q;
            s2_col_d   = s1_col_q;
            s2_out_d   = s1_out_q;
            s2_eol_d   = s1_eol_q;
            s2_last_d  = s1_last_q;
            if (s2_valid_q && s2_out_q) begin
                row_data_d = {s2_pix_q, rd_data};
                dv_d       = 1'b1;
                rse_d      = s2_eol_q;
                last_out_d = s2_last_q;
            end
        end
        if (frame_start) begin
            s1_last_d  = 1'b0;
            s2_last_d  = 1'b0;
            last_out_d = 1'b0;
        end
        over_d = last_out_q && !frame_start;
    end

    // Slot pair is {row r-1, row r-2}; the new pixel becomes r-1 and old r-1 shifts to r-2.
    assign ram_re    = s1_valid_q && module_en;
    assign ram_we    = s2_valid_q && module_en;
    assign ram_wdata = {s2_pix_q, rd_data[LW-1:PRECISION]};

    line_ram #(
        .DEPTH (IMG_W),
        .WIDTH (LW)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (s2_col_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (s1_col_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RF_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            s1_out_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pix_q   <= '0;
            s2_col_q   <= '0;
            s2_out_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            row_data_q <= '0;
            dv_q       <= 1'b0;
            rse_q      <= 1'b0;
            last_out_q <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_col_q   <= s1_col_d;
            s1_out_q   <= s1_out_d;
            s1_eol_q   <= s1_eol_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_pix_q   <= s2_pix_d;
            s2_col_q   <= s2_col_d;
            s2_out_q   <= s2_out_d;
            s2_eol_q   <= s2_eol_d;
            s2_last_q  <= s2_last_d;
            row_data_q <= row_data_d;
            dv_q       <= dv_d;
            rse_q      <= rse_d;
            last_out_q <= last_out_d;
            over_q     <= over_d;
        end
    end

    assign row_data      = row_data_q;
    assign din_valid     = {CROW{dv_q}};
    assign row_switch_en = rse_q;
    assign over          = over_q;

endmodule

// File: tb/tb_row_feeder.sv
// tb/tb_row_feeder.sv - randomized self-checking bench for row_feeder against a column-list model
module tb_row_feeder;
    import row_feeder_pkg::*;

    localparam int W       = 4;
    localparam int H       = 4;
    localparam int NPIX    = W * H;
    localparam int VM_CONT = 0;
    localparam int VM_GAP  = 1;
    localparam int VM_RAND = 2;

    logic        clk;
    logic        rst_n;
    logic        module_en;
    logic        frame_start;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] row_data;
    logic [2:0]  din_valid;
    logic        row_switch_en;
    logic        over;

    typedef struct packed {
        logic [23:0] data;
        logic        rse;
        logic        last;
        logic        first;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] pix_mem [NPIX];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_over_cyc = -1;
    int         first_out_cyc = 0;
    int         pix8_cyc = 0;
    bit         gap_mode = 0;
    bit         prev_dv = 0;

    row_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .module_en     (module_en),
        .frame_start   (frame_start),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .row_data      (row_data),
        .din_valid     (din_valid),
        .row_switch_en (row_switch_en),
        .over          (over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (din_valid != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_data", 32'(row_data), 32'(e.data));
                    chk("din_valid", 32'(din_valid), 32'h7);
                    chk("row_switch_en", 32'(row_switch_en), 32'(e.rse));
                    if (gap_mode) chk("gap_consecutive", 32'(prev_dv), 32'd0);
                    if (e.first) first_out_cyc = cyc;
                    if (e.last) exp_over_cyc = cyc + 1;
                end
            end else if (row_switch_en) begin
                chk("rse_without_valid", 32'd1, 32'd0);
            end
            if (over) begin
                chk("over_cycle", 32'(cyc), 32'(exp_over_cyc));
                exp_over_cyc = -1;
            end
            prev_dv = (din_valid != 3'b000);
        end else begin
            prev_dv = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_row_data"}, 32'(row_data), 32'd0);
        chk({tag, "_din_valid"}, 32'(din_valid), 32'd0);
        chk({tag, "_rse"}, 32'(row_switch_en), 32'd0);
        chk({tag, "_over"}, 32'(over), 32'd0);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(RF_IDLE));
    endtask

    // kind: 0 = 16r+c, 1 = random, 2 = 0x80+16r+c
    task automatic run_frame(input int kind, input int vmode, input bit with_start,
                             input int abort_idx, input int rst_idx, input int drop_idx);
        int idx;
        int step;
        int drop_left;
        int lim;
        bit en;
        bit v;
        bit got;
        exp_t ent;
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       pix_mem[i] = 8'(16 * (i / W) + (i % W));
                2:       pix_mem[i] = 8'(8'h80 + 16 * (i / W) + (i % W));
                default: pix_mem[i] = 8'($urandom);
            endcase
        end
        lim = NPIX;
        if (abort_idx >= 0) lim = abort_idx;
        if (rst_idx >= 0) lim = 0;
        for (int i = 2 * W; i < lim; i++) begin
            ent.data  = {pix_mem[i], pix_mem[i - W], pix_mem[i - 2 * W]};
            ent.rse   = ((i % W) == W - 1);
            ent.last  = (i == NPIX - 1);
            ent.first = (i == 2 * W);
            exp_q.push_back(ent);
        end
        gap_mode = (vmode == VM_GAP);
        if (with_start) begin
            @(posedge clk); #1;
            module_en   = 1'b1;
            pix_valid   = 1'b0;
            frame_start = 1'b1;
        end
        idx       = 0;
        step      = 0;
        drop_left = 5;
        while (idx < NPIX && step < 2000) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            en = 1'b1;
            v  = 1'b1;
            if (vmode == VM_GAP) begin
                v = (step % 2 == 0);
            end else if (vmode == VM_RAND) begin
                en = ($urandom_range(0, 5) != 0);
                v  = ($urandom_range(0, 3) != 0);
            end
            if (drop_idx == idx && drop_left > 0) begin
                en = 1'b0;
                drop_left--;
            end
            step++;
            if (abort_idx == idx) begin
                module_en   = 1'b1;
                frame_start = 1'b1;
                pix_valid   = 1'b1;
                pix_in      = pix_mem[idx];
                @(posedge clk); #1;
                frame_start = 1'b0;
                pix_valid   = 1'b0;
                chk("abort_state", 32'(dut.state_q), 32'(RF_FILL));
                return;
            end
            module_en = en;
            pix_valid = v;
            pix_in    = pix_mem[idx];
            #1;
            chk("pix_ready", 32'(pix_ready), 32'(en));
            if (!en && drop_idx == idx && drop_left <= 3) chk("en_low_din_valid", 32'(din_valid), 32'd0);
            if (rst_idx == idx) begin
                #1 rst_n = 1'b0;
                #1 check_idle_outputs("async_reset");
                exp_q.delete();
                exp_over_cyc = -1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    pix_in = 8'($urandom);
                    #1 chk("post_reset_ready", 32'(pix_ready), 32'd0);
                    @(posedge clk); #1;
                end
                pix_valid = 1'b0;
                chk("post_reset_no_out", 32'(exp_q.size()), 32'd0);
                return;
            end
            if (v && en) begin
                if (idx == 2 * W) pix8_cyc = cyc;
                idx++;
            end
        end
        if (step >= 2000) chk("drive_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        module_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (over) got = 1'b1;
        end
        chk("over_seen", 32'(got), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        module_en   = 1'b1;
        frame_start = 1'b0;
        pix_in      = 8'd0;
        pix_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;
        #1 chk("idle_ready", 32'(pix_ready), 32'd0);

        run_frame(0, VM_CONT, 1'b1, -1, -1, -1);
        chk("first_latency", 32'(first_out_cyc - pix8_cyc), 32'd3);

        run_frame(0, VM_GAP, 1'b1, -1, -1, -1);
        run_frame(0, VM_CONT, 1'b1, -1, -1, 9);

        run_frame(0, VM_CONT, 1'b1, 13, -1, -1);
        run_frame(1, VM_CONT, 1'b0, -1, -1, -1);

        run_frame(0, VM_CONT, 1'b1, -1, 9, -1);

        run_frame(0, VM_CONT, 1'b1, -1, -1, -1);
        run_frame(2, VM_CONT, 1'b1, -1, -1, -1);

        for (int n = 0; n < 4; n++) begin
            run_frame(1, VM_RAND, 1'b1, -1, -1, -1);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
